// File: rtl/coa_cpu_top.sv
// coa_cpu_top: minimal 8-bit single-cycle teaching CPU.
//   Internal ROM (image chosen by PROG_SEL), four 8-bit registers R0..R3,
//   zero flag, ALU, PC_W-bit program counter and a registered display bus.
//   One instruction completes on every rising CLK edge; there is no pipeline.
// Instruction word: op[15:12] rd[11:10] rs[9:8] imm[7:0].
// Optional feature macro: CPU_HALT_EN
//   defined   -> opcode F sets a sticky halted flag that freezes all state
//                until RST.
//   undefined -> opcode F executes as NOP.
// Ports:
//   CLK  in   system clock, rising edge active
//   RST  in   synchronous active-high reset
//   Dis  out  8-bit display register, written only by OUT (registered)
module coa_cpu_top #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned PROG_SEL = 0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [7:0] Dis
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
    OP_SUB  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_INC  = 4'h8, OP_OUT = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
    OP_JNZ  = 4'hC, OP_RSD = 4'hD, OP_RSE = 4'hE, OP_HLT = 4'hF
  } op_e;

  // Fixed program images; unlisted addresses read as NOP.
  function automatic logic [15:0] rom_word(input logic [PC_W-1:0] a);
    logic [15:0] w;
    w = 16'h0000;
    if (PROG_SEL == 0) begin
      case (32'(a))
        32'd0:   w = 16'h1000;
        32'd1:   w = 16'h1401;
        32'd2:   w = 16'h3100;
        32'd3:   w = 16'h9000;
        32'd4:   w = 16'hA002;
        default: w = 16'h0000;
      endcase
    end else if (PROG_SEL == 1) begin
      case (32'(a))
        32'd0:   w = 16'h185A;
        32'd1:   w = 16'h9200;
        32'd2:   w = 16'hF000;
        32'd3:   w = 16'h1811;
        32'd4:   w = 16'h9200;
        default: w = 16'h0000;
      endcase
    end
    return w;
  endfunction

  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_regs [4];
  logic            r_z;
  logic [7:0]      r_dis;

  logic [15:0]     w_instr;
  op_e             w_op;
  logic [1:0]      w_rd;
  logic [1:0]      w_rs;
  logic [7:0]      w_imm;
  logic [7:0]      w_rd_val;
  logic [7:0]      w_rs_val;
  logic            w_reg_we;
  logic [7:0]      w_wdata;
  logic            w_z_we;
  logic            w_dis_we;
  logic [PC_W-1:0] w_pc_next;
  logic            w_run;
  logic            w_set_halt;

  assign w_instr  = rom_word(r_pc);
  assign w_op     = op_e'(w_instr[15:12]);
  assign w_rd     = w_instr[11:10];
  assign w_rs     = w_instr[9:8];
  assign w_imm    = w_instr[7:0];
  // Both operands read the pre-edge register values, so Rd==Rs is safe.
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];

`ifdef CPU_HALT_EN
  logic r_halted;
  assign w_run = ~r_halted;
`else
  assign w_run = 1'b1;
`endif

  // Decode / ALU / next-PC.
  always_comb begin
    w_reg_we   = 1'b0;
    w_wdata    = 8'h00;
    w_z_we     = 1'b0;
    w_dis_we   = 1'b0;
    w_set_halt = 1'b0;
    w_pc_next  = r_pc + PC_W'(1);
    case (w_op)
      OP_LDI: begin w_reg_we = 1'b1; w_wdata = w_imm; end
      OP_MOV: begin w_reg_we = 1'b1; w_wdata = w_rs_val; end
      OP_ADD: begin w_reg_we = 1'b1; w_z_we = 1'b1; w_wdata = w_rd_val + w_rs_val; end
      OP_SUB: begin w_reg_we = 1'b1; w_z_we = 1'b1; w_wdata = w_rd_val - w_rs_val; end
      OP_AND: begin w_reg_we = 1'b1; w_z_we = 1'b1; w_wdata = w_rd_val & w_rs_val; end
      OP_OR:  begin w_reg_we = 1'b1; w_z_we = 1'b1; w_wdata = w_rd_val | w_rs_val; end
      OP_XOR: begin w_reg_we = 1'b1; w_z_we = 1'b1; w_wdata = w_rd_val ^ w_rs_val; end
      OP_INC: begin w_reg_we = 1'b1; w_z_we = 1'b1; w_wdata = w_rd_val + 8'd1; end
      OP_OUT: w_dis_we = 1'b1;
      OP_JMP: w_pc_next = PC_W'(w_imm);
      OP_JZ:  if (r_z)  w_pc_next = PC_W'(w_imm);
      OP_JNZ: if (!r_z) w_pc_next = PC_W'(w_imm);
      OP_HLT: w_set_halt = 1'b1;
      default: ;
    endcase
  end

  // Architectural state; reset wins over execution.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc  <= '0;
      r_z   <= 1'b0;
      r_dis <= 8'h00;
      for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
    end else if (w_run) begin
      r_pc <= w_pc_next;
      if (w_reg_we) r_regs[w_rd] <= w_wdata;
      if (w_z_we)   r_z          <= (w_wdata == 8'h00);
      if (w_dis_we) r_dis        <= w_rs_val;
    end
  end

`ifdef CPU_HALT_EN
  // Sticky halt; only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST)             r_halted <= 1'b0;
    else if (w_set_halt) r_halted <= 1'b1;
  end
`else
  logic w_unused;
  assign w_unused = w_set_halt;
`endif

  assign Dis = r_dis;

endmodule

// File: tb/tb_coa_cpu_top.sv
// Bench for coa_cpu_top: counter program (PROG_SEL=0) and halt-check
// program (PROG_SEL=1). Expected Dis values come from closed-form timing of
// each program and are queued before each edge, then popped and compared.
module tb_coa_cpu_top;

  logic       CLK = 1'b0;
  logic       RST0;
  logic       RST1;
  logic [7:0] dis0;
  logic [7:0] dis1;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  logic [7:0] sb_q[$];

  always #5 CLK = ~CLK;

  coa_cpu_top #(.PC_W(4), .PROG_SEL(0)) u_dut0 (.CLK(CLK), .RST(RST0), .Dis(dis0));
  coa_cpu_top #(.PC_W(4), .PROG_SEL(1)) u_dut1 (.CLK(CLK), .RST(RST1), .Dis(dis1));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counter program: Dis = floor((e-1)/3) mod 256 for e >= 1.
  function automatic logic [7:0] cnt_exp(input int e);
    return 8'(((e - 1) / 3) % 256);
  endfunction

  task automatic test_reset();
    logic [7:0] exp;
    @(negedge CLK); RST0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(8'h00);
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (dis0 !== exp) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: Dis=%02h expected %02h", i, dis0, exp);
      end
    end
    @(negedge CLK); RST0 = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 3; i++) begin
      edge_n++;
      sb_q.push_back(8'h00);
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (dis0 !== exp) begin
        errors++;
        $display("FAIL reset_release edge %0d: Dis=%02h expected %02h", edge_n, dis0, exp);
      end
    end
  endtask

  // Continues from edge 4 through 772: counting, 0xFF at 766, wrap at 769.
  task automatic test_counter();
    logic [7:0] exp;
    while (edge_n < 772) begin
      edge_n++;
      sb_q.push_back(cnt_exp(edge_n));
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (dis0 !== exp) begin
        errors++;
        $display("FAIL counter edge %0d: Dis=%02h expected %02h", edge_n, dis0, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp;
    @(negedge CLK); RST0 = 1'b1;
    tick();
    @(negedge CLK); RST0 = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 19; i++) begin
      edge_n++;
      sb_q.push_back(cnt_exp(edge_n));
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (dis0 !== exp) begin
        errors++;
        $display("FAIL mid_run edge %0d: Dis=%02h expected %02h", edge_n, dis0, exp);
      end
    end
    // Edge 20 with RST high: Dis would have stayed 0x06, reset forces 0x00.
    @(negedge CLK); RST0 = 1'b1;
    sb_q.push_back(8'h00);
    tick();
    exp = sb_q.pop_front();
    checks++;
    if (dis0 !== exp) begin
      errors++;
      $display("FAIL mid_reset edge 20: Dis=%02h expected %02h", dis0, exp);
    end
    @(negedge CLK); RST0 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      sb_q.push_back(e == 4 ? 8'h01 : 8'h00);
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (dis0 !== exp) begin
        errors++;
        $display("FAIL mid_restart edge %0d: Dis=%02h expected %02h", e, dis0, exp);
      end
    end
  endtask

  // Halt program: runs n edges after releasing RST1 and checks each one.
  task automatic run_halt_prog(input string name, input int n);
    logic [7:0] exp;
    logic [7:0] model;
    int k;
    model = 8'h00;
    @(negedge CLK); RST1 = 1'b1;
    sb_q.push_back(8'h00);
    tick();
    exp = sb_q.pop_front();
    checks++;
    if (dis1 !== exp) begin
      errors++;
      $display("FAIL %s reset: Dis=%02h expected %02h", name, dis1, exp);
    end
    @(negedge CLK); RST1 = 1'b0;
    for (int e = 1; e <= n; e++) begin
`ifdef CPU_HALT_EN
      k = e;
      if (k >= 2) model = 8'h5A;
`else
      // 16-word ROM: OUT R2 (0x5A) at slot 2, OUT R2 (0x11) at slot 5.
      k = ((e - 1) % 16) + 1;
      if (k == 2) model = 8'h5A;
      else if (k == 5) model = 8'h11;
`endif
      sb_q.push_back(model);
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (dis1 !== exp) begin
        errors++;
        $display("FAIL %s edge %0d: Dis=%02h expected %02h", name, e, dis1, exp);
      end
    end
  endtask

  task automatic test_halt();
    run_halt_prog("halt_run", 60);
  endtask

  task automatic test_halt_restart();
    run_halt_prog("halt_restart", 40);
  endtask

  initial begin
    RST0 = 1'b1;
    RST1 = 1'b1;
    test_reset();
    test_counter();
    test_mid_reset();
    RST0 = 1'b1;
    test_halt();
    test_halt_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coa_cpu_top.md
Name: coa_cpu_top

Overview:
- Top level of a minimal 8-bit single-cycle teaching CPU.
- Contains a fixed internal instruction ROM, four 8-bit general registers, a zero flag, an ALU, a program counter, and an 8-bit display output register.
- The only external interfaces are the clock, the reset, and the display bus `Dis`, which is driven exclusively by OUT instructions.

Parameters:
- PC_W, 4: program counter width; ROM depth is 2^PC_W words; PC wraps modulo 2^PC_W.
- PROG_SEL, 0: selects the ROM image.
  - 0 = counter program.
  - 1 = halt-check program.
  - Any other value = all NOP.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Dis  output 8  display register, registered output.

Behaviour:
- Reset (RST high at a rising edge):
  - PC=0, R0..R3=0, Z=0, Dis=0x00, halted=0.
  - Reset has priority over instruction execution.
  - Asserting reset mid-program aborts the program the same way.
- Execution model:
  - One instruction per cycle; no pipeline.
  - At each rising edge with RST low, the instruction at ROM[PC] completes: register, flag, Dis and PC updates all occur at that edge.
  - Default next PC = PC+1, wrapping from 2^PC_W-1 to 0.
- Instruction word is 16 bits: op[15:12], rd[11:10], rs[9:8], imm[7:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: Rd=imm. Z unchanged.
  - 2 MOV: Rd=Rs. Z unchanged.
  - 3 ADD: Rd=(Rd+Rs) mod 256, carry discarded, Z=(result==0).
  - 4 SUB: Rd=(Rd-Rs) mod 256, Z=(result==0).
  - 5 AND, 6 OR, 7 XOR: Rd=Rd op Rs, Z=(result==0).
  - 8 INC: Rd=Rd+1 mod 256, Z=(result==0).
  - 9 OUT: Dis=Rs.
  - A JMP: PC=imm[PC_W-1:0].
  - B JZ: jump if Z=1, else PC+1.
  - C JNZ: jump if Z=0, else PC+1.
  - D, E: NOP.
  - F HALT: see Optional Feature.
- Dis changes only on OUT or reset; it holds its value otherwise.
- Rd==Rs is legal for every opcode; it reads the old value, e.g. ADD R0,R0 doubles R0.
- ROM addresses beyond the program image read as 0x0000 (NOP).
- PROG_SEL=0 image:
  - 0: LDI R0,0x00 (0x1000)
  - 1: LDI R1,0x01 (0x1401)
  - 2: ADD R0,R1 (0x3100)
  - 3: OUT R0 (0x9000)
  - 4: JMP 2 (0xA002)
- PROG_SEL=0 timing:
  - Edges are numbered from the first rising edge with RST low (edge 1).
  - Dis becomes n (mod 256) at edge 1+3n.
  - So Dis=1 at edge 4, 2 at edge 7, 0xFF at edge 766, 0x00 at edge 769 (wrap).
- PROG_SEL=1 image:
  - 0: LDI R2,0x5A (0x185A)
  - 1: OUT R2 (0x9200)
  - 2: HALT (0xF000)
  - 3: LDI R2,0x11 (0x1811)
  - 4: OUT R2 (0x9200)

Optional Feature:
- Macro: CPU_HALT_EN.
- Defined:
  - Opcode F sets an internal halted flag.
  - While halted, PC, registers, Z and Dis are frozen.
  - Only RST clears the halted flag.
- Undefined:
  - Opcode F executes as NOP.
  - No halted flag exists.

Test Plan:
- Reset hold, PROG_SEL=0: RST high for 3 edges -> Dis=0x00 throughout, and 0x00 through edge 3 after release.
- Counter run, PROG_SEL=0: release RST -> Dis=0x01 after edge 4, 0x02 after edge 7, 0x03 after edge 10; unchanged on all intermediate edges.
- Wrap-around, PROG_SEL=0: run 769 edges -> Dis=0xFF after edge 766, 0x00 after edge 769, 0x01 after edge 772.
- Mid-run reset, PROG_SEL=0: assert RST at edge 20 (Dis=0x06) -> Dis=0x00 at that edge; after release Dis=0x01 after 4 more edges.
- Halt, PROG_SEL=1, CPU_HALT_EN defined: Dis=0x5A after edge 2 and stays 0x5A for 50+ edges; RST then restarts the program.
- Halt disabled, PROG_SEL=1, CPU_HALT_EN undefined: Dis=0x5A after edge 2, 0x11 after edge 5, then PC wraps via NOPs; the program repeats with Dis toggling 0x5A/0x11.
